// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin arbiter plus one-entry output buffer
// sitting in front of one NoC router output direction.
// Optional build macro ROUTER_OUTPUT_ARBITER_STATS_EN adds o_grantCount,
// a set of saturating 16-bit per-requester grant counters.

package pa_noc;
  localparam int PACKET_WIDTH = 8;
endpackage

module router_output_arbiter #(
  parameter  int NUM_REQ      = 5,
  localparam int PACKET_WIDTH = pa_noc::PACKET_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_srst,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] i_packet,
  input  logic [NUM_REQ-1:0]              i_valid,
  output logic [NUM_REQ-1:0]              o_ready,
  output logic [PACKET_WIDTH-1:0]         o_packet,
  output logic                            o_valid,
  input  logic                            i_ready
`ifdef ROUTER_OUTPUT_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           o_grantCount
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} bufState_t;

  bufState_t               state;
  bufState_t               stateNext;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        ptrNext;
  logic [PTR_W-1:0]        grantIdx;
  logic                    grantFound;
  logic                    canLoad;
  logic                    transfer;
  logic [PACKET_WIDTH-1:0] grantPacket;
  int                      candIdx;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      candIdx = int'(ptr) + i;
      if (candIdx >= NUM_REQ) candIdx = candIdx - NUM_REQ;
      if (!grantFound && i_valid[PTR_W'(candIdx)]) begin
        grantFound = 1'b1;
        grantIdx   = PTR_W'(candIdx);
      end
    end
  end

  // Winner's packet and the pointer value that follows it.
  always_comb begin
    grantPacket = i_packet[int'(grantIdx)*PACKET_WIDTH +: PACKET_WIDTH];
    ptrNext     = (grantIdx == PTR_W'(NUM_REQ-1)) ? '0 : grantIdx + 1'b1;
  end

  // Buffer FSM next state and grant; grant is suppressed while in reset.
  always_comb begin
    stateNext = state;
    o_ready   = '0;
    transfer  = 1'b0;
    canLoad   = (state == EMPTY) || i_ready;
    if (!i_srst && canLoad && grantFound) begin
      o_ready[grantIdx] = 1'b1;
      transfer          = 1'b1;
      stateNext         = FULL;
    end else if (state == FULL && i_ready) begin
      stateNext = EMPTY;
    end
  end

  // State, pointer and buffered packet registers.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state    <= EMPTY;
      ptr      <= '0;
      o_packet <= '0;
    end else begin
      state <= stateNext;
      if (transfer) begin
        ptr      <= ptrNext;
        o_packet <= grantPacket;
      end
    end
  end

  assign o_valid = (state == FULL);

`ifdef ROUTER_OUTPUT_ARBITER_STATS_EN
  logic [15:0] grantCount [NUM_REQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int k = 0; k < NUM_REQ; k++) grantCount[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (transfer && grantIdx == PTR_W'(k) && grantCount[k] != 16'hFFFF) begin
          grantCount[k] <= grantCount[k] + 16'd1;
        end
      end
    end
  end

  // Flatten the counters onto the output port.
  always_comb begin
    o_grantCount = '0;
    for (int k = 0; k < NUM_REQ; k++) o_grantCount[k*16 +: 16] = grantCount[k];
  end
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// tb_router_output_arbiter: directed vector table plus hand-written
// sequences for reset, round-robin rotation, backpressure and wrap.
// Counter checks run when ROUTER_OUTPUT_ARBITER_STATS_EN is defined.

module tb_router_output_arbiter;

  localparam int N  = 5;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          srst;
  logic [N*PW-1:0] packetBus;
  logic [N-1:0]  validVec;
  logic [N-1:0]  readyVec;
  logic [PW-1:0] outPacket;
  logic          outValid;
  logic          downReady;
`ifdef ROUTER_OUTPUT_ARBITER_STATS_EN
  logic [N*16-1:0] grantCount;
`endif

  int checks   = 0;
  int failures = 0;

  router_output_arbiter #(.NUM_REQ(N)) dut (
    .i_clk   (clk),
    .i_srst  (srst),
    .i_packet(packetBus),
    .i_valid (validVec),
    .o_ready (readyVec),
    .o_packet(outPacket),
    .o_valid (outValid),
    .i_ready (downReady)
`ifdef ROUTER_OUTPUT_ARBITER_STATS_EN
    ,
    .o_grantCount(grantCount)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    valid;
    logic            ready;
    logic [N*PW-1:0] bus;
    logic [N-1:0]    expReady;
    logic            expValid;
    logic [PW-1:0]   expPacket;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic r, input logic [N*PW-1:0] b);
    validVec  = v;
    downReady = r;
    packetBus = b;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    srst = 1'b1;
    applyStimulus('0, 1'b0, '0);
    stepClock();
    stepClock();
    srst = 1'b0;
  endtask

  initial begin
    srst = 1'b1;
    applyStimulus('0, 1'b0, '0);

    // Sequential table from reset: ptr starts at 0, buffer empty.
    vecs[0] = '{5'b00000, 1'b1, 40'h00_00_00_00_00, 5'b00000, 1'b0, 8'h00};
    vecs[1] = '{5'b01000, 1'b1, 40'h00_3C_00_00_00, 5'b01000, 1'b1, 8'h3C};
    vecs[2] = '{5'b11111, 1'b0, 40'h44_33_22_11_AA, 5'b00000, 1'b1, 8'h3C};
    vecs[3] = '{5'b11111, 1'b1, 40'h44_33_22_11_AA, 5'b10000, 1'b1, 8'h44};
    vecs[4] = '{5'b00011, 1'b1, 40'h44_33_22_11_AA, 5'b00001, 1'b1, 8'hAA};
    vecs[5] = '{5'b00011, 1'b1, 40'h44_33_22_11_AA, 5'b00010, 1'b1, 8'h11};
    vecs[6] = '{5'b00000, 1'b1, 40'h44_33_22_11_AA, 5'b00000, 1'b0, 8'h11};
    vecs[7] = '{5'b00000, 1'b0, 40'h44_33_22_11_AA, 5'b00000, 1'b0, 8'h11};
    vecs[8] = '{5'b00001, 1'b0, 40'h44_33_22_11_AA, 5'b00001, 1'b1, 8'hAA};
    vecs[9] = '{5'b11111, 1'b0, 40'h44_33_22_11_AA, 5'b00000, 1'b1, 8'hAA};

    doReset();
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_packet", 64'(outPacket), 64'd0);
    checkOutput("rst_ready", 64'(readyVec), 64'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].ready, vecs[i].bus);
      #1;
      checkOutput($sformatf("v%0d_ready", i), 64'(readyVec), 64'(vecs[i].expReady));
      stepClock();
      checkOutput($sformatf("v%0d_valid", i), 64'(outValid), 64'(vecs[i].expValid));
      checkOutput($sformatf("v%0d_packet", i), 64'(outPacket), 64'(vecs[i].expPacket));
    end

    // Reset mid-operation: load 0x5A from requester 2 (ptr moves to 3).
    doReset();
    applyStimulus(5'b00100, 1'b0, 40'h00_00_5A_00_00);
    stepClock();
    checkOutput("midrst_full", 64'(outPacket), 64'h5A);
    applyStimulus(5'b11111, 1'b1, 40'h55_44_33_22_11);
    srst = 1'b1;
    #1;
    checkOutput("midrst_ready_in_reset", 64'(readyVec), 64'd0);
    stepClock();
    checkOutput("midrst_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_packet", 64'(outPacket), 64'd0);
    checkOutput("midrst_ready", 64'(readyVec), 64'd0);
    srst = 1'b0;
    #1;
    checkOutput("midrst_first_grant", 64'(readyVec), 64'b00001);

    // All requesters valid: grants rotate 0..4,0 with one packet per cycle.
    doReset();
    applyStimulus(5'b11111, 1'b1, 40'h55_44_33_22_11);
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("rr%0d_ready", c), 64'(readyVec), 64'(1 << (c % 5)));
      stepClock();
      checkOutput($sformatf("rr%0d_valid", c), 64'(outValid), 64'd1);
      checkOutput($sformatf("rr%0d_packet", c), 64'(outPacket), 64'(8'h11 * ((c % 5) + 1)));
    end

    // Backpressure: hold 0x11 for four cycles, then same-cycle refill.
    doReset();
    applyStimulus(5'b00001, 1'b1, 40'h00_00_00_00_11);
    stepClock();
    applyStimulus(5'b11111, 1'b0, 40'h55_44_33_22_11);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("bp%0d_ready", c), 64'(readyVec), 64'd0);
      stepClock();
      checkOutput($sformatf("bp%0d_valid", c), 64'(outValid), 64'd1);
      checkOutput($sformatf("bp%0d_packet", c), 64'(outPacket), 64'h11);
    end
    downReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(readyVec), 64'b00010);
    stepClock();
    checkOutput("bp_release_valid", 64'(outValid), 64'd1);
    checkOutput("bp_release_packet", 64'(outPacket), 64'h22);

    // Sparse wrap: ptr=4 with only requesters 0 and 1 valid.
    doReset();
    applyStimulus(5'b01000, 1'b1, 40'h55_44_33_22_11);
    stepClock();
    applyStimulus(5'b00011, 1'b1, 40'h55_44_33_22_11);
    #1;
    checkOutput("wrap_grant0", 64'(readyVec), 64'b00001);
    stepClock();
    checkOutput("wrap_packet0", 64'(outPacket), 64'h11);
    #1;
    checkOutput("wrap_grant1", 64'(readyVec), 64'b00010);
    stepClock();
    checkOutput("wrap_packet1", 64'(outPacket), 64'h22);

`ifdef ROUTER_OUTPUT_ARBITER_STATS_EN
    // Saturation: 70000 transfers from requester 2.
    doReset();
    applyStimulus(5'b00100, 1'b1, 40'h55_44_33_22_11);
    for (int c = 0; c < 70000; c++) @(posedge clk);
    #1;
    applyStimulus('0, 1'b1, '0);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("stat_sat%0d", k), 64'(grantCount[k*16 +: 16]),
                  (k == 2) ? 64'hFFFF : 64'd0);
    end
    srst = 1'b1;
    stepClock();
    srst = 1'b0;
    checkOutput("stat_clear", 64'(grantCount), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_output_arbiter.md
# router_output_arbiter

Per-output-port arbiter and one-entry output buffer for the NoC router. Up to `NUM_REQ` input ports (local NI, North, South, East, West) that have routed a packet to the same output direction compete for that port. The block picks one winner per cycle using round-robin, registers the winning packet, and presents it downstream on a valid/ready handshake. One instance sits in front of each router output (`o_ni`, `o_north`, `o_south`, `o_east`, `o_west`).

## Interface
- `NUM_REQ`, default 5: number of requesters. Index 0 is NI, 1 N, 2 S, 3 E, 4 W. Legal range 2..8.
- `PACKET_WIDTH`, localparam, `pa_noc::PACKET_WIDTH`: packet width in bits.
- `i_clk`  in  1  clock; all logic is on its rising edge.
- `i_srst`  in  1  reset, synchronous, active-high.
- `i_packet`  in  `NUM_REQ*PACKET_WIDTH`  request packets; requester k occupies bits [k*PACKET_WIDTH +: PACKET_WIDTH].
- `i_valid`  in  `NUM_REQ`  per-requester valid.
- `o_ready`  out  `NUM_REQ`  per-requester ready. One-hot or zero; it is the grant.
- `o_packet`  out  `PACKET_WIDTH`  buffered packet to downstream.
- `o_valid`  out  1  buffer holds a packet.
- `i_ready`  in  1  downstream accepts the packet.
- `o_grantCount`  out  `NUM_REQ*16`  per-requester grant counters. Present only with `ROUTER_OUTPUT_ARBITER_STATS_EN`.

## Operation
- **Buffer FSM, two states.**
  - EMPTY (`o_valid`=0).
  - FULL (`o_valid`=1).
- **Load enable.** `canLoad = !o_valid || i_ready`.
- **Grant.**
  - When `canLoad` is high, the first requester with `i_valid` set is granted. The search starts at `ptr` and wraps modulo `NUM_REQ`.
  - `o_ready[g]`=1 for the granted requester only. All other bits are 0.
  - When `canLoad` is low or no requester is valid, `o_ready` = 0.
  - `o_ready` is combinational from `i_valid`, `ptr`, FSM state and `i_ready`. Requesters must not make `i_valid` depend on `o_ready`.
- **Transfer.** A requester transfers when `i_valid[g] && o_ready[g]`. On that edge:
  - `o_packet` <= `i_packet[g]`.
  - FSM goes to or stays in FULL.
  - `ptr` <= (g+1) mod `NUM_REQ`.
- **Drain.** `o_valid && i_ready` with no transfer goes to EMPTY. `o_packet` keeps its old value.
- **Simultaneous drain and load.** Stays FULL with the new packet. This gives full throughput of 1 packet/cycle.
- **Stall.** While `o_valid && !i_ready`, `o_packet` and `o_valid` hold stable and `o_ready` = 0.
- **`ptr` updates only on a transfer.** It is unchanged in idle cycles.
- **Fairness.** With all requesters continuously valid and `i_ready`=1, grants rotate 0,1,…,NUM_REQ-1,0,… Any continuously valid requester waits at most `NUM_REQ-1` transfers.
- **`ptr` width and wrap.** `ptr` is `$clog2(NUM_REQ)` bits. On wrap, `NUM_REQ-1`+1 becomes 0; values ≥ `NUM_REQ` are never reached.

## Timing
- **Reset values** while `i_srst`=1 at an edge:
  - `o_valid`=0, `o_packet`='0, `ptr`=0.
  - FSM is EMPTY.
  - Counters = 0.
- **During reset,** `o_ready` is forced to 0.
- **Reset mid-operation** discards any buffered packet. There is no transfer in a cycle where `i_srst`=1.
- **Latency.** A packet accepted at edge N is on `o_packet` with `o_valid`=1 after edge N. That is a 1-cycle latency.
- **Handshakes.** A downstream handshake completes at the edge where `o_valid && i_ready`. An upstream handshake completes at the edge where `i_valid[k] && o_ready[k]`.
- **Combinational paths.** The only combinational path is `i_valid`/`i_ready` → `o_ready`. There is no combinational path from input to `o_valid` or `o_packet`.

## Configuration
- **Macro:** `ROUTER_OUTPUT_ARBITER_STATS_EN`.
- **Defined:**
  - The `o_grantCount` port and `NUM_REQ` 16-bit counters exist.
  - Counter k increments on each transfer from requester k.
  - Counters saturate at 16'hFFFF and clear on `i_srst`.
- **Undefined:** neither the port nor the counters exist. Arbitration behaviour is identical in both cases.

## Test plan
- **Reset mid-operation:** assert `i_srst` while FULL with `o_packet`=0x5A → next cycle `o_valid`=0, `o_packet`=0, `o_ready`=0; after release the first grant starts from requester 0.
- **Single requester:** only `i_valid[3]`=1 with packet 0x3C, `i_ready`=1 → `o_ready`=5'b01000; 0x3C appears on `o_packet` one cycle later with `o_valid`=1.
- **All valid, `i_ready`=1 throughout:** grant order is 0,1,2,3,4,0 over six cycles, with one packet per cycle on the output.
- **Backpressure:** `i_ready`=0 while FULL with 0x11 for 4 cycles → `o_packet` stays 0x11, `o_valid`=1, `o_ready`=0 every cycle. Raise `i_ready` → same-cycle load of the next winner, and `o_valid` stays 1.
- **Sparse wrap:** `ptr`=4 and valids = 5'b00011 → requester 0 is granted, then `ptr`=1. The next grant goes to requester 1.
- **Stats (macro defined):** 70000 transfers from requester 2 → `o_grantCount[2]` = 16'hFFFF and all others = 0. Assert `i_srst` → all counters read 0.
